// File: rtl/ccw_input.sv
// ---------------------------------------------------------------------------
// ccw_input
//   Counter-clockwise ring input buffer for one router node. It holds one
//   1-flit buffer per virtual channel (even = vc bit 0, odd = vc bit 1).
//   Flits arrive from the upstream CCW link. Each buffered flit raises a
//   request toward either the ccw output stage (the flit continues around the
//   ring) or the PE output stage (the flit has arrived). The request is held
//   until the matching grant is seen.
//
//   Flit layout: [63] vc, [55:48] one-hot hop field (8'h00 = arrived),
//   all other bits are payload. No hop arithmetic is done in this block.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   polarity                 global phase: 0 = even VC external and odd VC
//                            internal, 1 = the reverse
//   ccwsi / ccwri / ccwdi    upstream strobe, ready and flit
//   data_out_even/odd        buffered flit per VC
//   request_{ccw,pe}_{even,odd}  per-VC requests (asserted only in REQ)
//   grant_{ccw,pe}_{even,odd}    per-VC grants from the output arbiters
//   err_overrun              sticky protocol-error flag; the port exists only
//                            when CCW_INPUT_ERRCHK_EN is defined
//
// Optional feature macro: CCW_INPUT_ERRCHK_EN
// ---------------------------------------------------------------------------
module ccw_input #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  polarity,
  input  logic                  ccwsi,
  output logic                  ccwri,
  input  logic [DATA_WIDTH-1:0] ccwdi,
  output logic [DATA_WIDTH-1:0] data_out_even,
  output logic [DATA_WIDTH-1:0] data_out_odd,
  output logic                  request_ccw_even,
  output logic                  request_ccw_odd,
  output logic                  request_pe_even,
  output logic                  request_pe_odd,
  input  logic                  grant_ccw_even,
  input  logic                  grant_ccw_odd,
  input  logic                  grant_pe_even,
  input  logic                  grant_pe_odd
`ifdef CCW_INPUT_ERRCHK_EN
  ,
  output logic                  err_overrun
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_REQ   = 2'd2
  } state_t;

  state_t r_state_even;
  state_t r_state_odd;
  state_t w_next_even;
  state_t w_next_odd;

  logic [DATA_WIDTH-1:0] r_data_even;
  logic [DATA_WIDTH-1:0] r_data_odd;

  logic w_wr_even;
  logic w_wr_odd;
  logic w_tgt_pe_even;
  logic w_tgt_pe_odd;
  logic w_gnt_even;
  logic w_gnt_odd;

  // Per-VC state transition. int_phase is the phase in which this VC is on
  // the router-internal side, which is when a buffered flit may start
  // requesting. Once in REQ the request is held regardless of phase.
  function automatic state_t f_next_state(input state_t cur,
                                          input logic   wr,
                                          input logic   int_phase,
                                          input logic   gnt);
    state_t nxt;
    nxt = cur;
    case (cur)
      ST_EMPTY: begin
        if (wr) nxt = ST_FULL;
        else    nxt = ST_EMPTY;
      end
      ST_FULL: begin
        if (int_phase) nxt = ST_REQ;
        else           nxt = ST_FULL;
      end
      ST_REQ: begin
        if (gnt) nxt = ST_EMPTY;
        else     nxt = ST_REQ;
      end
      default: nxt = ST_EMPTY;
    endcase
    return nxt;
  endfunction

  // The ready signal covers only the VC currently on the external link.
  assign ccwri = polarity ? (r_state_odd == ST_EMPTY) : (r_state_even == ST_EMPTY);

  // A write needs the flit's vc bit to match the external VC; others are dropped.
  assign w_wr_even = ccwsi & ~polarity & ~ccwdi[63] & (r_state_even == ST_EMPTY);
  assign w_wr_odd  = ccwsi &  polarity &  ccwdi[63] & (r_state_odd  == ST_EMPTY);

  // A zero hop field means the flit has reached this node.
  assign w_tgt_pe_even = (r_data_even[55:48] == 8'h00);
  assign w_tgt_pe_odd  = (r_data_odd[55:48]  == 8'h00);

  // Only the grant for the requested target counts.
  assign w_gnt_even = w_tgt_pe_even ? grant_pe_even : grant_ccw_even;
  assign w_gnt_odd  = w_tgt_pe_odd  ? grant_pe_odd  : grant_ccw_odd;

  // Next-state logic for both VC buffers.
  always_comb begin
    w_next_even = f_next_state(r_state_even, w_wr_even, polarity,  w_gnt_even);
    w_next_odd  = f_next_state(r_state_odd,  w_wr_odd,  ~polarity, w_gnt_odd);
  end

  // State registers for both VC buffers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_even <= ST_EMPTY;
      r_state_odd  <= ST_EMPTY;
    end else begin
      r_state_even <= w_next_even;
      r_state_odd  <= w_next_odd;
    end
  end

  // Flit storage. A buffer changes only on a write, so it stays stable after a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_even <= {DATA_WIDTH{1'b0}};
      r_data_odd  <= {DATA_WIDTH{1'b0}};
    end else begin
      if (w_wr_even) r_data_even <= ccwdi;
      if (w_wr_odd)  r_data_odd  <= ccwdi;
    end
  end

  assign data_out_even = r_data_even;
  assign data_out_odd  = r_data_odd;

  // Requests are asserted only in REQ, and only one target is requested per VC.
  assign request_ccw_even = (r_state_even == ST_REQ) & ~w_tgt_pe_even;
  assign request_pe_even  = (r_state_even == ST_REQ) &  w_tgt_pe_even;
  assign request_ccw_odd  = (r_state_odd  == ST_REQ) & ~w_tgt_pe_odd;
  assign request_pe_odd   = (r_state_odd  == ST_REQ) &  w_tgt_pe_odd;

`ifdef CCW_INPUT_ERRCHK_EN
  logic r_err_overrun;
  logic w_vc_mismatch;

  // The flit's vc bit disagrees with the VC that is currently external.
  assign w_vc_mismatch = (ccwdi[63] != polarity);

  // Sticky error: a strobe while not ready or on the wrong VC. Only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_overrun <= 1'b0;
    end else if (ccwsi & (~ccwri | w_vc_mismatch)) begin
      r_err_overrun <= 1'b1;
    end
  end

  assign err_overrun = r_err_overrun;
`endif

endmodule

// File: tb/tb_ccw_input.sv
module tb_ccw_input;

  logic        clk;
  logic        rst;
  logic        polarity;
  logic        ccwsi;
  logic        ccwri;
  logic [63:0] ccwdi;
  logic [63:0] data_out_even;
  logic [63:0] data_out_odd;
  logic        request_ccw_even;
  logic        request_ccw_odd;
  logic        request_pe_even;
  logic        request_pe_odd;
  logic        grant_ccw_even;
  logic        grant_ccw_odd;
  logic        grant_pe_even;
  logic        grant_pe_odd;
`ifdef CCW_INPUT_ERRCHK_EN
  logic        err_overrun;
`endif

  int checks;
  int failures;

  ccw_input #(.DATA_WIDTH(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .polarity         (polarity),
    .ccwsi            (ccwsi),
    .ccwri            (ccwri),
    .ccwdi            (ccwdi),
    .data_out_even    (data_out_even),
    .data_out_odd     (data_out_odd),
    .request_ccw_even (request_ccw_even),
    .request_ccw_odd  (request_ccw_odd),
    .request_pe_even  (request_pe_even),
    .request_pe_odd   (request_pe_odd),
    .grant_ccw_even   (grant_ccw_even),
    .grant_ccw_odd    (grant_ccw_odd),
    .grant_pe_even    (grant_pe_even),
    .grant_pe_odd     (grant_pe_odd)
`ifdef CCW_INPUT_ERRCHK_EN
    ,
    .err_overrun      (err_overrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per VC, whether a flit is held, whether it has
  // been offered to the arbiters yet, and the flit itself.
  bit          m_occ [2];
  bit          m_ann [2];
  logic [63:0] m_dat [2];
  bit          m_err;

  // Grants/requests as 4-bit vectors ordered {ccw_even, pe_even, ccw_odd, pe_odd}.
  typedef struct {
    logic        rst;
    logic        pol;
    logic        si;
    logic [63:0] di;
    logic [3:0]  g;
    logic        exp_ri;
    logic [3:0]  exp_req;
    logic [63:0] exp_de;
    logic [63:0] exp_do;
  } vec_t;

  vec_t tbl [26];

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [3:0] dut_req();
    return {request_ccw_even, request_pe_even, request_ccw_odd, request_pe_odd};
  endfunction

  // Advance the model across one clock edge using the inputs held at that edge.
  task automatic model_edge();
    bit ext;
    bit ready;
    bit pe;
    bit gv;
    if (rst) begin
      for (int v = 0; v < 2; v++) begin
        m_occ[v] = 1'b0;
        m_ann[v] = 1'b0;
        m_dat[v] = 64'h0;
      end
      m_err = 1'b0;
    end else begin
      ext   = polarity;
      ready = !m_occ[ext];
      if (ccwsi && (!ready || (ccwdi[63] != ext))) m_err = 1'b1;
      for (int v = 0; v < 2; v++) begin
        pe = (m_dat[v][55:48] == 8'h00);
        if (v == 0) gv = pe ? grant_pe_even : grant_ccw_even;
        else        gv = pe ? grant_pe_odd  : grant_ccw_odd;
        if (m_occ[v] && m_ann[v]) begin
          if (gv) begin
            m_occ[v] = 1'b0;
            m_ann[v] = 1'b0;
          end
        end else if (m_occ[v] && (polarity != v[0])) begin
          m_ann[v] = 1'b1;
        end
      end
      if (ccwsi && ready && (ccwdi[63] == ext)) begin
        m_occ[ext] = 1'b1;
        m_ann[ext] = 1'b0;
        m_dat[ext] = ccwdi;
      end
    end
  endtask

  task automatic model_compare(input int idx);
    logic [3:0] exp_req;
    for (int v = 0; v < 2; v++) begin
      exp_req[3-2*v] = m_occ[v] && m_ann[v] && (m_dat[v][55:48] != 8'h00);
      exp_req[2-2*v] = m_occ[v] && m_ann[v] && (m_dat[v][55:48] == 8'h00);
    end
    chk("mdl_ccwri", idx, {63'h0, ccwri}, {63'h0, !m_occ[polarity]});
    chk("mdl_req",   idx, {60'h0, dut_req()}, {60'h0, exp_req});
    chk("mdl_data_even", idx, data_out_even, m_dat[0]);
    chk("mdl_data_odd",  idx, data_out_odd,  m_dat[1]);
`ifdef CCW_INPUT_ERRCHK_EN
    chk("mdl_err", idx, {63'h0, err_overrun}, {63'h0, m_err});
`endif
  endtask

  // Hold inputs across one rising edge, then compare against the model 1 time unit later.
  task automatic step(input int idx, input logic r, input logic p, input logic s,
                      input logic [63:0] d, input logic [3:0] g);
    rst            = r;
    polarity       = p;
    ccwsi          = s;
    ccwdi          = d;
    grant_ccw_even = g[3];
    grant_pe_even  = g[2];
    grant_ccw_odd  = g[1];
    grant_pe_odd   = g[0];
    @(posedge clk);
    model_edge();
    #1;
    model_compare(idx);
  endtask

  initial begin
    logic [63:0] fe;
    logic [63:0] fo;
    logic [63:0] fe2;
    logic [63:0] fo2;
    logic [63:0] rd;
    logic        rp;
    logic        rs;
    logic        rr;
    logic [3:0]  rg;

    checks   = 0;
    failures = 0;
    rst = 1'b1; polarity = 1'b0; ccwsi = 1'b0; ccwdi = 64'h0;
    grant_ccw_even = 1'b0; grant_pe_even = 1'b0; grant_ccw_odd = 1'b0; grant_pe_odd = 1'b0;

    fe  = 64'h0002_1111_2222_3333;  // even, hop 02 -> ccw
    fo  = 64'h8000_4444_5555_6666;  // odd,  hop 00 -> pe
    fe2 = 64'h0010_AAAA_BBBB_CCCC;  // even, hop 10 -> ccw
    fo2 = 64'h8004_DDDD_EEEE_FFFF;  // odd,  hop 04 -> ccw

    //            rst   pol   si    di      g        ri    req      de     do
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 64'h0, 4'b0000, 1'b1, 4'b0000, 64'h0, 64'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 64'h0, 4'b0000, 1'b1, 4'b0000, 64'h0, 64'h0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, fe,    4'b0000, 1'b0, 4'b0000, fe,    64'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 64'h0, 4'b0000, 1'b1, 4'b1000, fe,    64'h0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 64'h0, 4'b1000, 1'b1, 4'b0000, fe,    64'h0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, fo,    4'b0000, 1'b0, 4'b0000, fe,    fo};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 64'h0, 4'b0000, 1'b1, 4'b0001, fe,    fo};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 64'h0, 4'b0010, 1'b0, 4'b0001, fe,    fo};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 64'h0, 4'b1100, 1'b1, 4'b0001, fe,    fo};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 64'h0, 4'b0000, 1'b0, 4'b0001, fe,    fo};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 64'h0, 4'b0000, 1'b1, 4'b0001, fe,    fo};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 64'h0, 4'b0000, 1'b0, 4'b0001, fe,    fo};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 64'h0, 4'b0001, 1'b1, 4'b0000, fe,    fo};
    tbl[13] = '{1'b0, 1'b0, 1'b1, fe2,   4'b0000, 1'b0, 4'b0000, fe2,   fo};
    tbl[14] = '{1'b0, 1'b1, 1'b1, fo2,   4'b0000, 1'b0, 4'b1000, fe2,   fo2};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 64'h0, 4'b0000, 1'b0, 4'b1010, fe2,   fo2};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 64'h0, 4'b1010, 1'b1, 4'b0000, fe2,   fo2};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 64'h0, 4'b0000, 1'b1, 4'b0000, fe2,   fo2};
    tbl[18] = '{1'b0, 1'b0, 1'b1, fo,    4'b0000, 1'b1, 4'b0000, fe2,   fo2};
    tbl[19] = '{1'b0, 1'b0, 1'b1, fe,    4'b0000, 1'b0, 4'b0000, fe,    fo2};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 64'h0, 4'b0000, 1'b1, 4'b1000, fe,    fo2};
    tbl[21] = '{1'b1, 1'b1, 1'b0, 64'h0, 4'b1000, 1'b1, 4'b0000, 64'h0, 64'h0};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 64'h0, 4'b0000, 1'b1, 4'b0000, 64'h0, 64'h0};
    tbl[23] = '{1'b0, 1'b1, 1'b0, 64'h0, 4'b0000, 1'b1, 4'b0000, 64'h0, 64'h0};
    tbl[24] = '{1'b0, 1'b0, 1'b1, fe,    4'b0000, 1'b0, 4'b0000, fe,    64'h0};
    tbl[25] = '{1'b0, 1'b0, 1'b1, fe2,   4'b0000, 1'b0, 4'b0000, fe,    64'h0};

    for (int i = 0; i < 26; i++) begin
      step(i, tbl[i].rst, tbl[i].pol, tbl[i].si, tbl[i].di, tbl[i].g);
      chk("tbl_ccwri",     i, {63'h0, ccwri}, {63'h0, tbl[i].exp_ri});
      chk("tbl_req",       i, {60'h0, dut_req()}, {60'h0, tbl[i].exp_req});
      chk("tbl_data_even", i, data_out_even, tbl[i].exp_de);
      chk("tbl_data_odd",  i, data_out_odd,  tbl[i].exp_do);
    end

`ifdef CCW_INPUT_ERRCHK_EN
    // Overrun flag is sticky across idle cycles and cleared only by rst.
    for (int i = 0; i < 3; i++) begin
      step(100 + i, 1'b0, i[0], 1'b0, 64'h0, 4'b0000);
      chk("err_sticky", 100 + i, {63'h0, err_overrun}, 64'h1);
    end
    step(110, 1'b1, 1'b0, 1'b0, 64'h0, 4'b0000);
    chk("err_cleared", 110, {63'h0, err_overrun}, 64'h0);
`endif

    // Randomized traffic against the model.
    step(200, 1'b1, 1'b0, 1'b0, 64'h0, 4'b0000);
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 199) == 0);
      rp = $urandom_range(0, 1) == 1;
      rs = $urandom_range(0, 2) != 0;
      rd = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rd[55:48] = 8'h00;
      rg = 4'($urandom_range(0, 15));
      step(1000 + i, rr, rp, rs, rd, rg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
